tone_meter: RTL and testbench

Avalon-MM slave that measures an external square wave and reports its period, frequency, edge count and status to the Nios II processor. It is the receive-side counterpart of the tone generator: the generator drives a speaker from a programmed frequency, and this block recovers the frequency from a pin, such as a microphone comparator or a looped-back `spkr`. It sits on the system interconnect beside the other lab peripherals and runs on the system clock.

---
 rtl/tone_meter_pkg.sv | 20 ++
 rtl/tone_meter_if.sv | 33 +++
 rtl/udiv32.sv | 74 +++++++
 rtl/tone_meter.sv | 164 ++++++++++++++++
 tb/tb_tone_meter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_meter_pkg.sv
// tone_meter_pkg: shared constants and types for the tone_meter block.
//   - Register addresses of the Avalon-MM register map.
//   - Bit positions inside the status register.
//   - 32-bit data word type used for all registers.
package tone_meter_pkg;

  typedef logic [31:0] word_t;

  // Register map (word addresses)
  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_FREQ   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_EDGES  = 2'd3;

  // Status register bit positions
  localparam int unsigned STAT_VALID = 0;
  localparam int unsigned STAT_BUSY  = 1;
  localparam int unsigned STAT_TMO   = 2;

endpackage

// File: rtl/tone_meter_if.sv
// tone_meter_if: Avalon-MM register bus between the processor and tone_meter.
//   address   : 2-bit word address
//   read      : read strobe, data returned one cycle later on readdata
//   readdata  : registered read data
//   write     : write strobe
//   writedata : write data
// Modports: master (processor side), slave (tone_meter side).
interface tone_meter_if;
  import tone_meter_pkg::*;

  logic [1:0] address;
  logic       read;
  logic       write;
  word_t      writedata;
  word_t      readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/udiv32.sv
// udiv32: sequential restoring unsigned divider, one quotient bit per cycle.
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   start    : load dividend/divisor and begin (restarts a running division)
//   abort    : cancel any running division; beats start
//   dividend : numerator, sampled on start
//   divisor  : denominator, sampled on start, must be non-zero
//   quotient : final quotient, meaningful only while done is high
//   busy     : division in progress
//   done     : 1-cycle pulse in the cycle the last quotient bit is formed
module udiv32
  import tone_meter_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  start,
  input  logic  abort,
  input  word_t dividend,
  input  word_t divisor,
  output word_t quotient,
  output logic  busy,
  output logic  done
);

  word_t       rem_q;
  word_t       acc_q;  // dividend bits shift out the top, quotient bits shift in the bottom
  word_t       dvs_q;
  logic [4:0]  cnt_q;
  logic        busy_q;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;
  word_t       rem_nx;
  word_t       acc_nx;
  logic        last;

  always_comb begin
    shifted = {rem_q, acc_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = (shifted >= {1'b0, dvs_q});
    rem_nx  = ge ? diff[31:0] : shifted[31:0];
    acc_nx  = {acc_q[30:0], ge};
    last    = (cnt_q == 5'd31);
  end

  assign quotient = acc_nx;
  assign busy     = busy_q;
  assign done     = busy_q & last & ~abort;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q  <= '0;
      acc_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      acc_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_nx;
      acc_q <= acc_nx;
      cnt_q <= cnt_q + 5'd1;
      if (last) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/tone_meter.sv
// tone_meter: measures an external square wave on sig and reports period,
// frequency, rising-edge count and status over an Avalon-MM slave port.
//   fclk    : clock frequency in Hz (frequency numerator and 1 s timeout)
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   sig     : measured input, asynchronous to clk
//   bus     : tone_meter_if.slave register port (read latency 1)
// Registers: 0 period, 1 freq, 2 status {tmo, busy, valid}, 3 edges.
// Build option: define TONE_METER_FREQ_EN to instantiate the udiv32 frequency
// divider; without it address 1 reads 0 and status busy stays 0.
module tone_meter
  import tone_meter_pkg::*;
#(
  parameter int unsigned fclk = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sig,
  tone_meter_if.slave bus
);

  localparam word_t CountMax = word_t'(fclk - 1);
  localparam word_t CountPre = word_t'(fclk - 2);

  logic  sig_s1_q, sig_s2_q, sig_d_q;
  word_t count_q;
  word_t period_q;
  word_t edges_q;
  word_t readdata_q;
  logic  armed_q;
  logic  valid_q;
  logic  tmo_q;

  logic  rise;
  logic  timeout;
  logic  capture;
  logic  tmo_clr;
  logic  busy;
  word_t freq;
  word_t rdata;
  logic  unused_wdata;

  assign rise    = sig_s2_q & ~sig_d_q;
  // One-shot: fires only on the step into saturation, so a later tmo clear sticks.
  assign timeout = ~rise & (count_q == CountPre);
  assign capture = rise & armed_q;
  assign tmo_clr = bus.write & (bus.address == REG_STATUS) & bus.writedata[STAT_TMO];

  // Only writedata[2] has a meaning.
  assign unused_wdata = ^{bus.writedata[31:3], bus.writedata[1:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sig_s1_q <= 1'b0;
      sig_s2_q <= 1'b0;
      sig_d_q  <= 1'b0;
      count_q  <= '0;
      period_q <= '0;
      edges_q  <= '0;
      armed_q  <= 1'b0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      sig_s1_q <= sig;
      sig_s2_q <= sig_s1_q;
      sig_d_q  <= sig_s2_q;

      if (rise) begin
        count_q <= '0;
      end else if (count_q != CountMax) begin
        count_q <= count_q + 32'd1;
      end

      if (rise) edges_q <= edges_q + 32'd1;

      if (rise) begin
        armed_q <= 1'b1;
        if (armed_q) begin
          period_q <= count_q + 32'd1;
          valid_q  <= 1'b1;
        end
      end else if (timeout) begin
        period_q <= '0;
        valid_q  <= 1'b0;
        armed_q  <= 1'b0;
      end

      if (timeout) begin
        tmo_q <= 1'b1;
      end else if (tmo_clr) begin
        tmo_q <= 1'b0;
      end
    end
  end

`ifdef TONE_METER_FREQ_EN
  logic  div_start_q;
  logic  div_busy;
  logic  div_done;
  word_t div_quotient;
  word_t freq_q;

  udiv32 u_udiv32 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start_q),
    .abort    (timeout),
    .dividend (word_t'(fclk)),
    .divisor  (period_q),
    .quotient (div_quotient),
    .busy     (div_busy),
    .done     (div_done)
  );

  // Start is delayed one cycle so the divider sees the freshly captured period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_start_q <= 1'b0;
      freq_q      <= '0;
    end else begin
      div_start_q <= capture;
      if (timeout) begin
        freq_q <= '0;
      end else if (div_done) begin
        freq_q <= div_quotient;
      end
    end
  end

  assign freq = freq_q;
  assign busy = div_busy | div_start_q;
`else
  logic unused_capture;

  assign unused_capture = capture;
  assign freq           = '0;
  assign busy           = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    unique case (bus.address)
      REG_PERIOD: rdata = period_q;
      REG_FREQ:   rdata = freq;
      REG_STATUS: begin
        rdata[STAT_VALID] = valid_q;
        rdata[STAT_BUSY]  = busy;
        rdata[STAT_TMO]   = tmo_q;
      end
      REG_EDGES:  rdata = edges_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (bus.read) begin
      readdata_q <= rdata;
    end
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_tone_meter.sv
// tb_tone_meter: directed self-checking bench for tone_meter with fclk = 1000.
// A background generator drives sig as a square wave of gen_period clk cycles
// (0 = held low) and counts the rising edges it produces.
module tb_tone_meter;
  import tone_meter_pkg::*;

  localparam int unsigned Fclk = 1000;
`ifdef TONE_METER_FREQ_EN
  localparam bit FreqEn = 1'b1;
`else
  localparam bit FreqEn = 1'b0;
`endif
  localparam word_t Exp10 = FreqEn ? 32'd10 : 32'd0;
  localparam word_t Exp25 = FreqEn ? 32'd25 : 32'd0;

  logic clk;
  logic reset_n;
  logic sig;

  tone_meter_if bus ();

  tone_meter #(
    .fclk (Fclk)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (sig),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Square-wave generator
  int gen_period = 0;
  int gen_rises  = 0;
  int gen_phase  = 0;

  initial begin
    sig = 1'b0;
    forever begin
      if (gen_period == 0) begin
        sig       = 1'b0;
        gen_phase = 0;
        @(posedge clk);
        #1;
      end else begin
        int p;
        p = gen_period;
        for (int i = 0; i < p; i++) begin
          gen_phase = i;
          sig       = (i < p / 2);
          if (i == 0) gen_rises++;
          @(posedge clk);
          #1;
        end
      end
    end
  end

  task automatic rd(input logic [1:0] a, output word_t v);
    @(posedge clk);
    #1;
    bus.address = a;
    bus.read    = 1'b1;
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    v        = bus.readdata;
  endtask

  task automatic wr(input logic [1:0] a, input word_t d);
    @(posedge clk);
    #1;
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input word_t exp);
    word_t v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    word_t v;
    int    bad;
    bit    seen1;
    int    guard;

    bus.address   = '0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = '0;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_readdata", bus.readdata, 32'd0);
    chk_rd("rst_period", REG_PERIOD, 32'd0);
    chk_rd("rst_freq",   REG_FREQ,   32'd0);
    chk_rd("rst_status", REG_STATUS, 32'd0);
    chk_rd("rst_edges",  REG_EDGES,  32'd0);

    // Period 100 square wave
    gen_period = 100;
    wait_cycles(260);
    chk_rd("p100_period", REG_PERIOD, 32'd100);
    rd(REG_STATUS, v);
    check("p100_valid", 32'(v[STAT_VALID]), 32'd1);
    check("p100_tmo", 32'(v[STAT_TMO]), 32'd0);
    chk_rd("p100_freq", REG_FREQ, Exp10);
    seen1 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rd(REG_STATUS, v);
      if (v[STAT_BUSY]) seen1 = 1'b1;
    end
    check("p100_busy_seen", 32'(seen1), 32'(FreqEn));

    // Switch to period 40 while the divider keeps restarting
    gen_period = 40;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      rd(REG_FREQ, v);
      if (v !== Exp10 && v !== Exp25) bad++;
    end
    check("p40_partial_reads", 32'(bad), 32'd0);
    chk_rd("p40_period", REG_PERIOD, 32'd40);
    chk_rd("p40_freq",   REG_FREQ,   Exp25);
    wr(REG_PERIOD, 32'hFFFF_FFFF);
    wr(REG_FREQ,   32'hFFFF_FFFF);
    chk_rd("wr0_ignored", REG_PERIOD, 32'd40);
    chk_rd("wr1_ignored", REG_FREQ,   Exp25);

    // Timeout with sig held low
    gen_period = 0;
    wait_cycles(1100);
    chk_rd("tmo_period", REG_PERIOD, 32'd0);
    chk_rd("tmo_freq",   REG_FREQ,   32'd0);
    chk_rd("tmo_status", REG_STATUS, 32'd4);
    chk_rd("tmo_edges",  REG_EDGES,  32'(gen_rises));
    wr(REG_EDGES, 32'd0);
    chk_rd("wr3_ignored", REG_EDGES, 32'(gen_rises));
    wr(REG_STATUS, 32'd0);
    chk_rd("tmo_keep", REG_STATUS, 32'd4);
    wr(REG_STATUS, 32'd4);
    chk_rd("tmo_clear", REG_STATUS, 32'd0);

    // Read latency and hold
    rd(REG_PERIOD, v);
    @(posedge clk);
    #1;
    bus.address = REG_EDGES;
    bus.read    = 1'b1;
    @(negedge clk);
    check("rt_before_edge", bus.readdata, 32'd0);
    @(posedge clk);
    #1;
    bus.read    = 1'b0;
    bus.address = REG_PERIOD;
    check("rt_latency1", bus.readdata, 32'(gen_rises));
    wait_cycles(3);
    @(negedge clk);
    check("rt_hold", bus.readdata, 32'(gen_rises));

    // Reset mid-measurement, during the low half of the wave
    gen_period = 100;
    wait_cycles(250);
    guard = 0;
    while (gen_phase != 60 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    check("sync_wait_expired", 32'(guard >= 500), 32'd0);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("mid_rst_readdata", bus.readdata, 32'd0);
    chk_rd("mid_rst_period", REG_PERIOD, 32'd0);
    chk_rd("mid_rst_freq",   REG_FREQ,   32'd0);
    chk_rd("mid_rst_status", REG_STATUS, 32'd0);
    chk_rd("mid_rst_edges",  REG_EDGES,  32'd0);
    wait_cycles(60);
    chk_rd("arm_period", REG_PERIOD, 32'd0);
    chk_rd("arm_status", REG_STATUS, 32'd0);
    chk_rd("arm_edges",  REG_EDGES,  32'd1);
    wait_cycles(100);
    chk_rd("rearm_period", REG_PERIOD, 32'd100);
    chk_rd("rearm_edges",  REG_EDGES,  32'd2);
    rd(REG_STATUS, v);
    check("rearm_valid", 32'(v[STAT_VALID]), 32'd1);
    wait_cycles(40);
    chk_rd("rearm_freq", REG_FREQ, Exp10);

    // Exact timeout boundary from reset with sig idle
    gen_period = 0;
    wait_cycles(110);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (997) @(posedge clk);
    #1;
    bus.address = REG_STATUS;
    bus.read    = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("tmo_cycle_998", bus.readdata, 32'd0);
    @(posedge clk);
    #1;
    check("tmo_cycle_999", bus.readdata, 32'd4);
    bus.read = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
